// File: rtl/sd_multi_piece.sv
// Multi-piece 1st/2nd-order sigma-delta modulator with coefficient sequencer.
// Optional LFSR dither into stage 1 when SD_MULTI_DITHER_EN is defined.
module sd_multi_piece #(
  parameter int BITWIDTH = 40,
  parameter int NPIECE   = 4,
  parameter int SELW     = 2,
  parameter int HOLDW    = 16,
  parameter int FBSHIFT  = 16,
  parameter int RESETVAL = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NPIECE*BITWIDTH-1:0] kin,
  input  logic [SELW-1:0]            sel,
  input  logic                       auto,
  input  logic [SELW-1:0]            last_piece,
  input  logic [HOLDW-1:0]           hold_len,
  input  logic                       order2,
  input  logic                       sat_clr,
  output logic                       sd_out,
  output logic [SELW-1:0]            piece_idx,
  output logic                       sat_flag,
  output logic [BITWIDTH-1:0]        acc1_mon
);

  localparam logic [SELW-1:0] MAXI = SELW'(NPIECE - 1);
  localparam logic [BITWIDTH-1:0] ONE = BITWIDTH'(1);
  localparam logic [BITWIDTH-1:0] FBP = ONE << FBSHIFT;
  localparam logic [BITWIDTH-1:0] FBN = ~FBP + ONE;
  localparam logic [BITWIDTH-1:0] RV  = BITWIDTH'(RESETVAL);

  // MSB of the result flags a clamp; low bits are the clamped sum
  function automatic logic [BITWIDTH:0] sat_add(
    input logic [BITWIDTH-1:0] a,
    input logic [BITWIDTH-1:0] b
  );
    logic [BITWIDTH:0] s;
    s = {a[BITWIDTH-1], a} + {b[BITWIDTH-1], b};
    if (s[BITWIDTH] != s[BITWIDTH-1])
      return {1'b1, s[BITWIDTH], {(BITWIDTH-1){~s[BITWIDTH]}}};
    return {1'b0, s[BITWIDTH-1:0]};
  endfunction

  logic [BITWIDTH-1:0] k_arr [NPIECE];

  for (genvar i = 0; i < NPIECE; i++) begin : g_k
    assign k_arr[i] = kin[i*BITWIDTH +: BITWIDTH];
  end

  logic [BITWIDTH-1:0] acc1, acc2;
  logic [SELW-1:0]     idx, idx_n, sel_c, lim, cur;
  logic [HOLDW-1:0]    cnt, cnt_n, cur_cnt;
  logic                auto_q, start;

  assign sel_c   = (sel > MAXI) ? MAXI : sel;
  assign lim     = (last_piece > MAXI) ? MAXI : last_piece;
  assign start   = auto & ~auto_q;
  assign cur     = start ? sel_c : idx;
  assign cur_cnt = start ? '0 : cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx    <= '0;
      cnt    <= '0;
      auto_q <= 1'b0;
    end else begin
      idx    <= idx_n;
      cnt    <= cnt_n;
      auto_q <= auto;
    end
  end

  always_comb begin
    idx_n = cur;
    cnt_n = cur_cnt;
    if (!auto) begin
      idx_n = sel_c;
      cnt_n = '0;
    end else if (enable) begin
      if (cur_cnt == hold_len) begin
        cnt_n = '0;
        idx_n = (cur >= lim) ? '0 : cur + 1'b1;
      end else begin
        cnt_n = cur_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    piece_idx = auto ? cur : sel_c;
    if (reset) piece_idx = '0;
  end

  logic [BITWIDTH-1:0] k, fb, acc1_n, acc2_n;
  logic [BITWIDTH:0]   r1, r2, r3, r4;
  logic                clip, sd_n;

  assign k  = k_arr[piece_idx];
  assign fb = sd_out ? FBN : FBP;
  assign r1 = sat_add(k, fb);
  assign r2 = sat_add(r1[BITWIDTH-1:0], acc1);

`ifdef SD_MULTI_DITHER_EN
  logic [15:0]         lfsr;
  logic [BITWIDTH-1:0] dith;
  logic [BITWIDTH:0]   rd;

  assign dith = {{(BITWIDTH-8){lfsr[7]}}, lfsr[7:0]};
  assign rd   = sat_add(r2[BITWIDTH-1:0], dith);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      lfsr <= 16'hACE1;
    else if (enable)
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign acc1_n = rd[BITWIDTH-1:0];
  wire   clip1  = r1[BITWIDTH] | r2[BITWIDTH] | rd[BITWIDTH];
`else
  assign acc1_n = r2[BITWIDTH-1:0];
  wire   clip1  = r1[BITWIDTH] | r2[BITWIDTH];
`endif

  assign r3     = sat_add(acc1_n, fb);
  assign r4     = sat_add(r3[BITWIDTH-1:0], acc2);
  assign acc2_n = order2 ? r4[BITWIDTH-1:0] : RV;
  assign clip   = clip1 | (order2 & (r3[BITWIDTH] | r4[BITWIDTH]));
  assign sd_n   = order2 ? ~acc2_n[BITWIDTH-1] : ~acc1_n[BITWIDTH-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc1     <= RV;
      acc2     <= RV;
      sd_out   <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      if (enable) begin
        acc1   <= acc1_n;
        acc2   <= acc2_n;
        sd_out <= sd_n;
      end
      // a clamp in the same cycle outranks a clear request
      if (enable && clip)
        sat_flag <= 1'b1;
      else if (sat_clr)
        sat_flag <= 1'b0;
    end
  end

  assign acc1_mon = acc1;

endmodule

// File: tb/tb_sd_multi_piece.sv
// Self-checking bench for sd_multi_piece (default build, no dither).
// Uses a spec-level arithmetic model plus spec-given constant sequences.
module tb_sd_multi_piece;

  localparam int BW = 40;
  localparam int NP = 4;
  localparam longint MAXV = (64'sd1 <<< 39) - 1;
  localparam longint MINV = -(64'sd1 <<< 39);
  localparam longint FB   = 65536;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           enable = 1'b0;
  logic [NP*BW-1:0] kin = '0;
  logic [1:0]     sel = '0;
  logic           auto = 1'b0;
  logic [1:0]     last_piece = 2'd3;
  logic [15:0]    hold_len = '0;
  logic           order2 = 1'b0;
  logic           sat_clr = 1'b0;
  logic           sd_out;
  logic [1:0]     piece_idx;
  logic           sat_flag;
  logic [BW-1:0]  acc1_mon;

  sd_multi_piece dut (
    .clk(clk), .reset(reset), .enable(enable), .kin(kin),
    .sel(sel), .auto(auto), .last_piece(last_piece),
    .hold_len(hold_len), .order2(order2), .sat_clr(sat_clr),
    .sd_out(sd_out), .piece_idx(piece_idx),
    .sat_flag(sat_flag), .acc1_mon(acc1_mon)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  longint km [NP];
  longint m_acc1, m_acc2;
  bit     m_sd, m_flag, m_autoq, m_clip;
  int     m_idx, m_cnt;

  function automatic longint sat(longint a, longint b);
    longint s = a + b;
    if (s > MAXV) begin m_clip = 1; return MAXV; end
    if (s < MINV) begin m_clip = 1; return MINV; end
    return s;
  endfunction

  function automatic int clampi(int v, int m);
    return (v > m) ? m : v;
  endfunction

  function automatic int mpidx();
    int sc = clampi(int'(sel), NP - 1);
    if (reset) return 0;
    if (!auto || !m_autoq) return sc;
    return m_idx;
  endfunction

  function automatic longint dut_acc1();
    return longint'($signed(acc1_mon));
  endfunction

  task automatic pack();
    for (int i = 0; i < NP; i++) kin[i*BW +: BW] = km[i][BW-1:0];
  endtask

  task automatic model_step();
    int p = mpidx();
    int sc = clampi(int'(sel), NP - 1);
    longint fb, a1n, a2n;
    m_clip = 0;
    if (enable) begin
      fb  = m_sd ? -FB : FB;
      a1n = sat(sat(km[p], fb), m_acc1);
      a2n = order2 ? sat(sat(a1n, fb), m_acc2) : 0;
      m_sd   = order2 ? (a2n >= 0) : (a1n >= 0);
      m_acc1 = a1n;
      m_acc2 = a2n;
    end
    if (enable && m_clip) m_flag = 1;
    else if (sat_clr) m_flag = 0;
    if (!auto) begin
      m_idx = sc;
      m_cnt = 0;
    end else begin
      int cur = m_autoq ? m_idx : sc;
      int c = m_autoq ? m_cnt : 0;
      if (enable) begin
        if (c == int'(hold_len)) begin
          c = 0;
          cur = (cur >= clampi(int'(last_piece), NP - 1)) ? 0 : cur + 1;
        end else begin
          c++;
        end
      end
      m_idx = cur;
      m_cnt = c;
    end
    m_autoq = auto;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_acc1 = 0; m_acc2 = 0; m_sd = 0; m_flag = 0;
    m_autoq = 0; m_idx = 0; m_cnt = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    total++;
    if (acc1_mon !== '0 || sd_out !== 1'b0 || piece_idx !== 2'd0 || sat_flag !== 1'b0) begin
      bad++;
      $display("FAIL power_up_reset acc1=%h sd=%b idx=%0d flag=%b want all 0",
               acc1_mon, sd_out, piece_idx, sat_flag);
    end
    do_reset();
    km[2] = MAXV; pack();
    sel = 2'd2; enable = 1'b1;
    repeat (8) tick();
    total++;
    if (sat_flag !== 1'b1 || piece_idx !== 2'd2) begin
      bad++;
      $display("FAIL pre_reset_state flag=%b idx=%0d want 1/2", sat_flag, piece_idx);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (acc1_mon !== '0 || sd_out !== 1'b0 || piece_idx !== 2'd0 || sat_flag !== 1'b0) begin
      bad++;
      $display("FAIL async_reset acc1=%h sd=%b idx=%0d flag=%b want all 0",
               acc1_mon, sd_out, piece_idx, sat_flag);
    end
    sel = 2'd0; enable = 1'b0; km[2] = 0; pack();
    do_reset();
  endtask

  task automatic test_order1_zero();
    longint a_exp [5] = '{65536, 0, -65536, 0, -65536};
    bit     s_exp [5] = '{1, 1, 0, 1, 0};
    int ones = 0;
    do_reset();
    for (int i = 0; i < NP; i++) km[i] = 0;
    pack();
    sel = 0; auto = 0; order2 = 0; enable = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (dut_acc1() !== a_exp[i] || sd_out !== s_exp[i]) begin
        bad++;
        $display("FAIL order1_seq[%0d] acc1=%0d sd=%b want %0d/%b",
                 i, dut_acc1(), sd_out, a_exp[i], s_exp[i]);
      end
    end
    for (int i = 0; i < 64; i++) begin
      tick();
      ones += int'(sd_out);
    end
    total++;
    if (ones < 31 || ones > 33) begin
      bad++;
      $display("FAIL order1_density ones=%0d want 32+-1", ones);
    end
  endtask

  task automatic test_density();
    int ones, errs;
    do_reset();
    km[0] = 32768; pack();
    sel = 0; auto = 0; enable = 1;
    for (int o = 0; o < 2; o++) begin
      order2 = o[0];
      repeat (32) tick();
      ones = 0; errs = 0;
      for (int i = 0; i < 256; i++) begin
        tick();
        ones += int'(sd_out);
        if (dut_acc1() !== m_acc1 || sd_out !== m_sd) errs++;
      end
      total++;
      if (ones < 190 || ones > 194) begin
        bad++;
        $display("FAIL density_order%0d ones=%0d want 192+-2", o + 1, ones);
      end
      total++;
      if (errs !== 0) begin
        bad++;
        $display("FAIL density_model_order%0d mismatches=%0d want 0", o + 1, errs);
      end
    end
    enable = 0;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dut_acc1() !== m_acc1 || sd_out !== m_sd) errs++;
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL enable_freeze mismatches=%0d want 0", errs);
    end
  endtask

  task automatic test_order2_switch();
    int ones = 0, errs = 0;
    do_reset();
    km[0] = 0; pack();
    sel = 0; auto = 0; order2 = 1; enable = 1;
    repeat (100) begin
      tick();
      if (dut_acc1() !== m_acc1 || sd_out !== m_sd) errs++;
    end
    order2 = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      ones += int'(sd_out);
      if (dut_acc1() !== m_acc1 || sd_out !== m_sd) errs++;
    end
    total++;
    if (ones < 30 || ones > 34) begin
      bad++;
      $display("FAIL order2_to_1_density ones=%0d want ~32", ones);
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL order2_switch_model mismatches=%0d want 0", errs);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    km[0] = MAXV; pack();
    sel = 0; auto = 0; order2 = 0; enable = 1;
    repeat (4) tick();
    total++;
    if (dut_acc1() !== MAXV || sd_out !== 1'b1 || sat_flag !== 1'b1) begin
      bad++;
      $display("FAIL sat_pos acc1=%h sd=%b flag=%b want 7fffffffff/1/1",
               acc1_mon, sd_out, sat_flag);
    end
    sat_clr = 1;
    tick();
    total++;
    if (sat_flag !== 1'b1) begin
      bad++;
      $display("FAIL sat_set_wins flag=%b want 1", sat_flag);
    end
    enable = 0;
    tick();
    total++;
    if (sat_flag !== 1'b0) begin
      bad++;
      $display("FAIL sat_clr flag=%b want 0", sat_flag);
    end
    sat_clr = 0; enable = 1;
    tick();
    total++;
    if (sat_flag !== 1'b1 || dut_acc1() !== MAXV) begin
      bad++;
      $display("FAIL sat_reset_again flag=%b acc1=%h want 1/7fffffffff", sat_flag, acc1_mon);
    end
    km[0] = MINV; pack();
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (dut_acc1() !== m_acc1 || sd_out !== m_sd || sat_flag !== m_flag) begin
        bad++;
        $display("FAIL sat_neg[%0d] acc1=%0d sd=%b flag=%b want %0d/%b/%b",
                 i, dut_acc1(), sd_out, sat_flag, m_acc1, m_sd, m_flag);
      end
    end
    km[0] = 0; pack();
  endtask

  task automatic test_sequencer();
    bit en_p [14] = '{1,1,1,1,1,1,0,0,1,1,1,1,1,1};
    int ex_p [14] = '{1,1,1,1,2,2,2,2,2,2,0,0,0,0};
    int exp_i;
    do_reset();
    auto = 0; sel = 1; last_piece = 2; hold_len = 3; enable = 1;
    tick();
    auto = 1;
    for (int i = 0; i < 16; i++) begin
      exp_i = (1 + i / 4) % 3;
      total++;
      if (int'(piece_idx) !== exp_i) begin
        bad++;
        $display("FAIL seq_run[%0d] idx=%0d want %0d", i, piece_idx, exp_i);
      end
      tick();
    end
    auto = 0;
    tick();
    auto = 1;
    for (int i = 0; i < 14; i++) begin
      enable = en_p[i];
      total++;
      if (int'(piece_idx) !== ex_p[i]) begin
        bad++;
        $display("FAIL seq_stall[%0d] idx=%0d want %0d", i, piece_idx, ex_p[i]);
      end
      tick();
    end
    auto = 0; sel = 3; enable = 1;
    #1;
    total++;
    if (piece_idx !== 2'd3) begin
      bad++;
      $display("FAIL direct_sel idx=%0d want 3", piece_idx);
    end
  endtask

  task automatic test_random();
    int shown = 0;
    logic [39:0] r;
    do_reset();
    for (int i = 0; i < NP; i++) km[i] = $urandom_range(0, 131072) - 65536;
    pack();
    for (int n = 0; n < 3000; n++) begin
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 31) == 0) auto = ~auto;
      if ($urandom_range(0, 63) == 0) order2 = ~order2;
      sel = 2'($urandom);
      if ($urandom_range(0, 15) == 0) last_piece = 2'($urandom);
      if ($urandom_range(0, 15) == 0) hold_len = 16'($urandom_range(0, 5));
      sat_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 15) == 0) begin
        int j = $urandom_range(0, NP - 1);
        case ($urandom_range(0, 3))
          0: begin
            r = {8'($urandom), $urandom};
            km[j] = longint'($signed(r));
          end
          1: km[j] = MAXV - $urandom_range(0, 1000);
          2: km[j] = MINV + $urandom_range(0, 1000);
          default: km[j] = $urandom_range(0, 262144) - 131072;
        endcase
        pack();
      end
      #1;
      total++;
      if (int'(piece_idx) !== mpidx()) begin
        bad++;
        if (shown++ < 10)
          $display("FAIL rand_idx[%0d] idx=%0d want %0d", n, piece_idx, mpidx());
      end
      tick();
      total++;
      if (dut_acc1() !== m_acc1 || sd_out !== m_sd || sat_flag !== m_flag) begin
        bad++;
        if (shown++ < 10)
          $display("FAIL rand_out[%0d] acc1=%0d sd=%b flag=%b want %0d/%b/%b",
                   n, dut_acc1(), sd_out, sat_flag, m_acc1, m_sd, m_flag);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NP; i++) km[i] = 0;
    pack();
    test_reset();
    test_order1_zero();
    test_density();
    test_order2_switch();
    test_saturation();
    test_sequencer();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
